maj_net_sequencer: RTL

Time-multiplexed evaluator for programmable 7-input majority-gate networks. A single 3-input majority unit is shared across up to 8 gate nodes, one node per cycle. The block sweeps all 128 input patterns and assembles the network's 128-bit truth table. It sits in front of the function-classification flow: software programs a network, starts a sweep, and reads back the truth-table signature.

---
 rtl/maj_net_sequencer_if.sv | 24 ++
 rtl/maj_net_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/maj_net_sequencer_if.sv
// Bus bundle for maj_net_sequencer: configuration writes, sweep request,
// status pulses and the assembled truth table.
interface maj_net_sequencer_if;
  logic         cfg_we;
  logic [3:0]   cfg_addr;
  logic [11:0]  cfg_wdata;
  logic         start;
  logic         busy;
  logic         done;
  logic         err;
  logic [127:0] tt;

  // Host side: programs the network and starts sweeps.
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start,
    input  busy, done, err, tt
  );

  // Sequencer side.
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start,
    output busy, done, err, tt
  );
endinterface

// File: rtl/maj_net_sequencer.sv
// Time-multiplexed evaluator for a programmable network of up to eight
// 3-input majority gates over seven primary inputs. One gate is evaluated
// per cycle; all 128 input patterns are swept to build a 128-bit truth table.
module maj_net_sequencer (
  input  logic                  clk,
  input  logic                  rst_n,
  maj_net_sequencer_if.slave    bus
);

  localparam int unsigned NUM_GATES_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Majority of three operands.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Resolve one 4-bit operand select: 0 = constant 0, 1..7 = x0..x6,
  // 8..15 = current per-pattern gate value w0..w7.
  function automatic logic sel_operand(input logic [3:0] sel,
                                       input logic [7:0] x,
                                       input logic [7:0] w);
    logic [2:0] idx;
    logic       val;
    idx = sel[2:0] - 3'd1;
    case (sel[3])
      1'b0: begin
        if (sel[2:0] == 3'd0) begin
          val = 1'b0;
        end else begin
          val = x[idx];
        end
      end
      1'b1:    val = w[sel[2:0]];
      default: val = 1'b0;
    endcase
    return val;
  endfunction

  state_e                           state_q, state_d;
  logic [3:0]                       n_q, n_d;
  logic [NUM_GATES_MAX-1:0][11:0]   prog_q, prog_d;
  logic [6:0]                       pattern_q, pattern_d;
  logic [2:0]                       gate_q, gate_d;
  logic [7:0]                       w_q, w_d;
  logic [127:0]                     tt_q, tt_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             err_q, err_d;

  logic [11:0]                      entry_s;
  logic [7:0]                       x_s;
  logic                             op_a_s, op_b_s, op_c_s;
  logic                             w_new_s;
  logic                             last_gate_s;

  // Shared majority datapath for the gate currently addressed by gate_q.
  always_comb begin
    entry_s     = prog_q[gate_q];
    x_s         = {1'b0, pattern_q};
    op_a_s      = sel_operand(entry_s[3:0],  x_s, w_q);
    op_b_s      = sel_operand(entry_s[7:4],  x_s, w_q);
    op_c_s      = sel_operand(entry_s[11:8], x_s, w_q);
    w_new_s     = maj3(op_a_s, op_b_s, op_c_s);
    last_gate_s = ({1'b0, gate_q} == (n_q - 4'd1));
  end

  // Next-state, configuration and sweep bookkeeping.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    prog_d    = prog_q;
    pattern_d = pattern_q;
    gate_d    = gate_q;
    w_d       = w_q;
    tt_d      = tt_q;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The write is resolved first so a same-cycle start sees it.
        if (bus.cfg_we) begin
          if (bus.cfg_addr < 4'd8) begin
            prog_d[bus.cfg_addr[2:0]] = bus.cfg_wdata;
          end else if (bus.cfg_addr == 4'd8) begin
            if ((bus.cfg_wdata[3:0] >= 4'd1) && (bus.cfg_wdata[3:0] <= 4'd8)) begin
              n_d = bus.cfg_wdata[3:0];
            end else begin
              err_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          prog_d = prog_q;
        end

        if (bus.start) begin
          if (n_d == 4'd0) begin
            err_d = 1'b1;
          end else begin
            state_d   = ST_EVAL;
            tt_d      = 128'd0;
            pattern_d = 7'd0;
            gate_d    = 3'd0;
            w_d       = 8'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EVAL: begin
        if (bus.cfg_we || bus.start) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end

        if (last_gate_s) begin
          // Network output for this pattern; gate values restart at 0.
          tt_d[pattern_q] = w_new_s;
          w_d             = 8'd0;
          gate_d          = 3'd0;
          pattern_d       = pattern_q + 7'd1;
          if (pattern_q == 7'd127) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EVAL;
          end
        end else begin
          w_d[gate_q] = w_new_s;
          gate_d      = gate_q + 3'd1;
        end
      end

      ST_DONE: begin
        if (bus.cfg_we || bus.start) begin
          err_d = 1'b1;
        end else begin
          err_d = 1'b0;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_EVAL);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n_q       <= 4'd0;
      prog_q    <= '0;
      pattern_q <= 7'd0;
      gate_q    <= 3'd0;
      w_q       <= 8'd0;
      tt_q      <= 128'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      prog_q    <= prog_d;
      pattern_q <= pattern_d;
      gate_q    <= gate_d;
      w_q       <= w_d;
      tt_q      <= tt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;
  assign bus.tt   = tt_q;

endmodule
